// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types and constants for the video timing generator.
// Colour-bar table is consumed only when VTG_TEST_PATTERN_EN is defined.
package vtg_pkg;

  typedef logic [11:0] coord_t;
  typedef logic [12:0] span_t;

  typedef struct packed {
    span_t active;
    span_t fp;
    span_t sync;
    span_t bp;
  } axis_t;

  // White, yellow, cyan, green, magenta, red, blue, black
  localparam logic [0:7][23:0] BAR_RGB = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic in_active(coord_t c, axis_t a);
    return {1'b0, c} < a.active;
  endfunction

  function automatic logic in_sync(coord_t c, axis_t a);
    span_t lo;
    span_t hi;
    lo = a.active + a.fp;
    hi = lo + a.sync;
    return ({1'b0, c} >= lo) && ({1'b0, c} < hi);
  endfunction

endpackage

// File: rtl/vtg_timing_gen_if.sv
// vtg_timing_gen_if: video timing bundle towards the TMDS encoder.
// o_rgb exists only when VTG_TEST_PATTERN_EN is defined.
interface vtg_timing_gen_if;
  import vtg_pkg::*;

  logic   o_hs;
  logic   o_vs;
  logic   o_de;
  coord_t o_x;
  coord_t o_y;
  logic   o_sof;
`ifdef VTG_TEST_PATTERN_EN
  logic [23:0] o_rgb;
`endif

  modport master (
    output o_hs, o_vs, o_de, o_x, o_y, o_sof
`ifdef VTG_TEST_PATTERN_EN
    , output o_rgb
`endif
  );

  modport slave (
    input o_hs, o_vs, o_de, o_x, o_y, o_sof
`ifdef VTG_TEST_PATTERN_EN
    , input o_rgb
`endif
  );

endinterface

// File: rtl/vtg_pattern.sv
// vtg_pattern: eight vertical colour bars, registered alongside o_de.
// Instantiated only when VTG_TEST_PATTERN_EN is defined.
module vtg_pattern
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  input  coord_t      h_cnt,
  input  logic        de,
  output logic [23:0] o_rgb
);

  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  coord_t      bar;
  logic [23:0] rgb_d;

  assign bar = h_cnt / coord_t'(BAR_W);

  // Leftover pixels when H_ACTIVE is not a multiple of 8 stay black
  always_comb begin
    rgb_d = '0;
    if (de) begin
      if (bar > coord_t'(7))
        rgb_d = BAR_RGB[7];
      else
        rgb_d = BAR_RGB[bar[2:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_rgb <= '0;
    else if (i_ce)
      o_rgb <= rgb_d;
  end

endmodule

// File: rtl/vtg_timing_gen.sv
// vtg_timing_gen: raster counters with registered sync/DE/coordinate decode.
// Define VTG_TEST_PATTERN_EN to add the colour-bar output o_rgb.
module vtg_timing_gen
  import vtg_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  vtg_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("vtg_timing_gen: H_TOTAL/V_TOTAL exceed 4096");
  end

  localparam axis_t H_AX = '{
    active: span_t'(H_ACTIVE), fp: span_t'(H_FP),
    sync:   span_t'(H_SYNC),   bp: span_t'(H_BP)
  };
  localparam axis_t V_AX = '{
    active: span_t'(V_ACTIVE), fp: span_t'(V_FP),
    sync:   span_t'(V_SYNC),   bp: span_t'(V_BP)
  };

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_last;
  logic   v_last;
  logic   de;
  logic   hs;
  logic   vs;
  logic   sof;

  logic   de_q;
  logic   hs_q;
  logic   vs_q;
  logic   sof_q;
  coord_t x_q;
  coord_t y_q;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // v_cnt only moves on the line wrap, so vs toggles at h_cnt=0
  assign de  = in_active(h_cnt, H_AX) && in_active(v_cnt, V_AX);
  assign hs  = in_sync(h_cnt, H_AX) ? SYNC_POL : ~SYNC_POL;
  assign vs  = in_sync(v_cnt, V_AX) ? SYNC_POL : ~SYNC_POL;
  assign sof = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      sof_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (i_ce) begin
      h_cnt <= h_last ? '0 : h_cnt + coord_t'(1);
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + coord_t'(1);
      de_q  <= de;
      hs_q  <= hs;
      vs_q  <= vs;
      sof_q <= sof;
      x_q   <= de ? h_cnt : '0;
      y_q   <= de ? v_cnt : '0;
    end
  end

  assign vid.o_de  = de_q;
  assign vid.o_hs  = hs_q;
  assign vid.o_vs  = vs_q;
  assign vid.o_sof = sof_q;
  assign vid.o_x   = x_q;
  assign vid.o_y   = y_q;

`ifdef VTG_TEST_PATTERN_EN
  logic [23:0] rgb;

  vtg_pattern #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_ce  (i_ce),
    .h_cnt (h_cnt),
    .de    (de),
    .o_rgb (rgb)
  );

  assign vid.o_rgb = rgb;
`endif

endmodule

// File: tb/tb_vtg_timing_gen.sv
// tb_vtg_timing_gen: randomized raster checks against a position-based model.
// Colour-bar checks run only when VTG_TEST_PATTERN_EN is defined.
module tb_vtg_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  always #5 clk = ~clk;

  vtg_timing_gen_if vid ();

  vtg_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_ce  (ce),
    .vid   (vid)
  );

`ifdef VTG_TEST_PATTERN_EN
  logic rst2 = 1'b1;
  logic ce2  = 1'b1;

  vtg_timing_gen_if vid2 ();

  vtg_timing_gen dut2 (
    .i_clk (clk),
    .i_rst (rst2),
    .i_ce  (ce2),
    .vid   (vid2)
  );
`endif

  int tests = 0;
  int fails = 0;
  int n     = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs after n enabled edges since reset:
  // they show the decode of raster position n-1 (mod frame).
  task automatic check_outputs();
    int p, h, v, ex, ey;
    logic ehs, evs, ede, esof;
    if (n == 0) begin
      ede = 0; ehs = 1; evs = 1; esof = 0; ex = 0; ey = 0;
    end else begin
      p    = (n - 1) % FRAME;
      h    = p % HT;
      v    = p / HT;
      ede  = (h < HA) && (v < VA);
      ehs  = !((h >= HA + HF) && (h < HA + HF + HS));
      evs  = !((v >= VA + VF) && (v < VA + VF + VS));
      esof = (p == 0);
      ex   = ede ? h : 0;
      ey   = ede ? v : 0;
    end
    check("hs",  32'(vid.o_hs),  32'(ehs));
    check("vs",  32'(vid.o_vs),  32'(evs));
    check("de",  32'(vid.o_de),  32'(ede));
    check("sof", 32'(vid.o_sof), 32'(esof));
    check("x",   32'(vid.o_x),   32'(ex));
    check("y",   32'(vid.o_y),   32'(ey));
  endtask

  task automatic step(input logic c, input logic r);
    ce  = c;
    rst = r;
    @(posedge clk);
    if (r) n = 0;
    else if (c) n++;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int last, vs_low, vs_start, de_cnt, sof_run;
    logic [7:0] hs_mask;

    @(negedge clk);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Continuous enable: first output, sync placement, sof period
    last = -1; vs_low = 0; vs_start = -1; de_cnt = 0; hs_mask = '0;
    for (int i = 0; i < 2 * FRAME + 1; i++) begin
      step(1'b1, 1'b0);
      if (i == 0) begin
        check("first.sof", 32'(vid.o_sof), 32'd1);
        check("first.de",  32'(vid.o_de),  32'd1);
        check("first.x",   32'(vid.o_x),   32'd0);
        check("first.y",   32'(vid.o_y),   32'd0);
      end
      if (i < HT && !vid.o_hs) hs_mask[i] = 1'b1;
      if (i < FRAME) begin
        if (!vid.o_vs) vs_low++;
        if (!vid.o_vs && vs_start < 0) vs_start = i;
        if (vid.o_de) de_cnt++;
      end
      if (vid.o_sof) begin
        if (last >= 0) check("sof.period", 32'(i - last), 32'(FRAME));
        last = i;
      end
    end
    check("hs.low_mask", 32'(hs_mask), 32'h60);
    check("vs.low_cycles", 32'(vs_low), 32'd8);
    check("vs.start", 32'(vs_start), 32'(4 * HT));
    check("de.cycles", 32'(de_cnt), 32'(HA * VA));

    // Alternating enable: outputs hold while ce=0
    step(1'b0, 1'b1);
    sof_run = 0;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      step(i[0] == 1'b0, 1'b0);
      if (i < 4 && vid.o_sof) sof_run++;
    end
    check("sof.hold_clocks", 32'(sof_run), 32'd2);

    // Random enable with occasional resets
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0);

    // Reset while hs and vs are both asserted
    step(1'b1, 1'b1);
    for (int i = 0; i < 4 * HT + 6; i++) step(1'b1, 1'b0);
    check("pre_rst.hs", 32'(vid.o_hs), 32'd0);
    check("pre_rst.vs", 32'(vid.o_vs), 32'd0);
    step(1'b1, 1'b1);
    check("rst.hs", 32'(vid.o_hs), 32'd1);
    check("rst.vs", 32'(vid.o_vs), 32'd1);
    check("rst.de", 32'(vid.o_de), 32'd0);
    hs_mask = '0;
    for (int i = 0; i < FRAME + 8; i++) begin
      step(1'b1, 1'b0);
      if (i < HT && !vid.o_hs) hs_mask[i] = 1'b1;
    end
    check("restart.hs_mask", 32'(hs_mask), 32'h60);

`ifdef VTG_TEST_PATTERN_EN
    begin
      logic [23:0] bars [8];
      logic [23:0] exp;
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      check("pat.rst_rgb", 32'(vid2.o_rgb), 32'h0);
      rst2 = 1'b0;
      for (int k = 0; k < 800; k++) begin
        @(posedge clk);
        @(negedge clk);
        exp = (k < 640) ? bars[k / 80] : 24'h000000;
        check("pat.rgb", 32'(vid2.o_rgb), 32'(exp));
        if (k == 0)   check("pat.x0",   32'(vid2.o_rgb), 32'hFFFFFF);
        if (k == 80)  check("pat.x80",  32'(vid2.o_rgb), 32'hFFFF00);
        if (k == 639) check("pat.x639", 32'(vid2.o_rgb), 32'h000000);
        if (k == 700) check("pat.blank", 32'(vid2.o_rgb), 32'h000000);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
